// File: rtl/uart_core_if.sv
// uart_core_if: word-level interface between user logic and uart_core.
//   master modport (user logic): drives tx_data/tx_valid; sees tx_ready, tx_busy,
//                                rx_data, rx_valid, frame_err, parity_err.
//   slave modport (uart_core):   the mirror image.
interface uart_core_if #(
    parameter int unsigned DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_busy;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 parity_err;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_busy, rx_data, rx_valid, frame_err, parity_err
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_busy, rx_data, rx_valid, frame_err, parity_err
    );
endinterface

// File: rtl/uart_core.sv
// uart_core: full-duplex UART with a shared 16x baud tick, 16x-oversampled receiver and
// valid/ready transmitter.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : uart_core_if.slave (tx_data/tx_valid/tx_ready/tx_busy,
//              rx_data/rx_valid/frame_err/parity_err)
//   tx       : serial out, idles high
//   rx       : serial in, asynchronous to clk
// Optional feature: define UART_PARITY_EN to honour PARITY (1 = odd, 2 = even).
// Without it parity logic is absent and parity_err is tied low.
module uart_core #(
    parameter int unsigned CLK_FREQ  = 27_000_000,
    parameter int unsigned BAUD_RATE = 115200,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned PARITY    = 0
) (
    input  logic       clk,
    input  logic       rst,
    uart_core_if.slave bus,
    output logic       tx,
    input  logic       rx
);
    localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD_RATE * 16);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned CW      = (DIV > 1) ? $clog2(DIV) : 1;

`ifdef UART_PARITY_EN
    localparam bit PAR_ON  = (PARITY != 0);
    localparam bit PAR_ODD = (PARITY == 1);
`else
    // PARITY is accepted but has no effect in this build.
    localparam bit PAR_ON  = (PARITY != 0) && 1'b0;
`endif

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    // ---------------------------------------------------------------- baud tick
    logic [CW-1:0] div_cnt;
    logic          tick;

    always_ff @(posedge clk) begin
        if (rst || div_cnt == CW'(DIV - 1)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == CW'(DIV - 1));

    // ---------------------------------------------------------------- transmitter
    state_e               tx_state, tx_state_next;
    logic [3:0]           tx_tick_cnt;
    logic [3:0]           tx_bit_cnt;
    logic [DATA_BITS-1:0] tx_shift;
    logic [CW-1:0]        tx_phase;
    logic                 alive;
    logic                 tx_accept;
    logic                 tx_tick;
    logic                 tx_bit_end;
    logic                 tx_par_bit;
    logic                 tx_ready_int;
    logic                 tx_busy_int;

    // TX ticks at the divider phase captured on acceptance, so every TX bit lasts exactly
    // 16*DIV cycles from the accepting edge while still sharing the single counter.
    assign tx_tick    = (div_cnt == tx_phase);
    assign tx_bit_end = tx_tick && (tx_tick_cnt == 4'd15);
    assign tx_accept  = bus.tx_valid && tx_ready_int;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= StIdle;
        end else begin
            tx_state <= tx_state_next;
        end
    end

    always_comb begin
        tx_state_next = tx_state;
        case (tx_state)
            StIdle:   if (tx_accept) tx_state_next = StStart;
            StStart:  if (tx_bit_end) tx_state_next = StData;
            StData: begin
                if (tx_bit_end && tx_bit_cnt == 4'(DATA_BITS - 1)) begin
                    tx_state_next = PAR_ON ? StParity : StStop;
                end
            end
            StParity: if (tx_bit_end) tx_state_next = StStop;
            StStop: begin
                if (tx_bit_end && tx_bit_cnt == 4'(STOP_BITS - 1)) tx_state_next = StIdle;
            end
            default:  tx_state_next = StIdle;
        endcase
    end

    always_comb begin
        tx_ready_int = (tx_state == StIdle) && alive;
        tx_busy_int  = (tx_state != StIdle);
        case (tx_state)
            StStart:  tx = 1'b0;
            StData:   tx = tx_shift[0];
            StParity: tx = tx_par_bit;
            default:  tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alive       <= 1'b0;
            tx_tick_cnt <= '0;
            tx_bit_cnt  <= '0;
            tx_shift    <= '0;
            tx_phase    <= '0;
        end else begin
            // alive delays tx_ready by one edge after reset release
            alive <= 1'b1;
            if (tx_accept) begin
                tx_shift    <= bus.tx_data;
                tx_phase    <= div_cnt;
                tx_tick_cnt <= '0;
                tx_bit_cnt  <= '0;
            end else if (tx_state != StIdle && tx_tick) begin
                tx_tick_cnt <= tx_tick_cnt + 1'b1;
                if (tx_bit_end) begin
                    if (tx_state_next != tx_state) begin
                        tx_bit_cnt <= '0;
                    end else begin
                        tx_bit_cnt <= tx_bit_cnt + 1'b1;
                    end
                    if (tx_state == StData) tx_shift <= tx_shift >> 1;
                end
            end
        end
    end

`ifdef UART_PARITY_EN
    logic tx_par_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_par_q <= 1'b0;
        end else if (tx_accept) begin
            tx_par_q <= PAR_ODD ? ~(^bus.tx_data) : (^bus.tx_data);
        end
    end
    assign tx_par_bit = tx_par_q;
`else
    assign tx_par_bit = 1'b0;
`endif

    assign bus.tx_ready = tx_ready_int;
    assign bus.tx_busy  = tx_busy_int;

    // ---------------------------------------------------------------- receiver
    state_e               rx_state, rx_state_next;
    logic                 rx_s1, rx_s2, rx_prev;
    logic [3:0]           rx_tick_cnt;
    logic [3:0]           rx_bit_cnt;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_fall;
    logic                 rx_mid;
    logic                 rx_done;
    logic                 perr_calc;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 parity_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall = rx_prev && !rx_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= StIdle;
        end else begin
            rx_state <= rx_state_next;
        end
    end

    always_comb begin
        rx_state_next = rx_state;
        case (rx_state)
            StIdle:   if (rx_fall) rx_state_next = StStart;
            StStart:  if (rx_mid) rx_state_next = rx_s2 ? StIdle : StData;
            StData: begin
                if (rx_mid && rx_bit_cnt == 4'(DATA_BITS - 1)) begin
                    rx_state_next = PAR_ON ? StParity : StStop;
                end
            end
            StParity: if (rx_mid) rx_state_next = StStop;
            // Leave at mid first stop bit; any second stop bit is not checked.
            StStop:   if (rx_mid) rx_state_next = StIdle;
            default:  rx_state_next = StIdle;
        endcase
    end

    // Start is sampled after 8 ticks; every following bit 16 ticks later (mid-bit).
    always_comb begin
        rx_mid  = 1'b0;
        if (tick) begin
            if (rx_state == StStart) begin
                rx_mid = (rx_tick_cnt == 4'd7);
            end else if (rx_state != StIdle) begin
                rx_mid = (rx_tick_cnt == 4'd15);
            end
        end
        rx_done = (rx_state == StStop) && rx_mid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_tick_cnt <= '0;
            rx_bit_cnt  <= '0;
            rx_shift    <= '0;
        end else begin
            if (rx_state_next != rx_state) begin
                rx_tick_cnt <= '0;
                rx_bit_cnt  <= '0;
            end else begin
                if (tick) rx_tick_cnt <= rx_tick_cnt + 1'b1;
                if (rx_mid) rx_bit_cnt <= rx_bit_cnt + 1'b1;
            end
            if (rx_state == StData && rx_mid) begin
                rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
            end
        end
    end

`ifdef UART_PARITY_EN
    logic rx_par_bit;
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_par_bit <= 1'b0;
        end else if (rx_state == StParity && rx_mid) begin
            rx_par_bit <= rx_s2;
        end
    end
    assign perr_calc = PAR_ON && ((^rx_shift ^ rx_par_bit) != PAR_ODD);
`else
    assign perr_calc = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            rx_valid_q <= rx_done;
            if (rx_done) begin
                rx_data_q    <= rx_shift;
                frame_err_q  <= !rx_s2;
                parity_err_q <= perr_calc;
            end
        end
    end

    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.parity_err = parity_err_q;
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: self-checking bench for uart_core at DIV = 10 (160 cycles per bit).
// Build with UART_PARITY_EN to exercise 9-bit even-parity frames.
`timescale 1ns/1ps
module tb_uart_core;
`ifdef UART_PARITY_EN
    localparam int unsigned DW   = 9;
    localparam int unsigned PAR  = 2;
    localparam bit          P_ON = 1'b1;
`else
    localparam int unsigned DW   = 8;
    localparam int unsigned PAR  = 0;
    localparam bit          P_ON = 1'b0;
`endif
    localparam int unsigned BIT   = 160;
    localparam int unsigned NBITS = 1 + DW + (P_ON ? 1 : 0) + 1;
    localparam int unsigned FRAME = NBITS * BIT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;
    logic rx;
    logic loop_en = 1'b0;
    logic rx_drv = 1'b1;

    uart_core_if #(.DATA_BITS(DW)) bus ();

    uart_core #(
        .CLK_FREQ (1_600_000),
        .BAUD_RATE(10_000),
        .DATA_BITS(DW),
        .STOP_BITS(1),
        .PARITY   (PAR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave),
        .tx (tx),
        .rx (rx)
    );

    assign rx = loop_en ? tx : rx_drv;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed receive words, recorded independently of the checking thread.
    int            rx_pulses = 0;
    logic [DW-1:0] obs_data [64];
    logic          obs_ferr [64];
    logic          obs_perr [64];
    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) begin
            obs_data[rx_pulses % 64] <= bus.rx_data;
            obs_ferr[rx_pulses % 64] <= bus.frame_err;
            obs_perr[rx_pulses % 64] <= bus.parity_err;
            rx_pulses <= rx_pulses + 1;
        end
    end

    typedef struct {
        logic [DW-1:0] data;
        logic          ferr;
        logic          perr;
    } exp_t;
    exp_t exp_q[$];
    int   rd_idx = 0;

    typedef struct {
        logic [8:0] data;
        logic       stop;
        logic       pflip;
        logic [8:0] exp_data;
        logic       exp_ferr;
        logic       exp_perr;
    } rxvec_t;
    rxvec_t vt[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [NBITS-1:0] frame_bits(input logic [DW-1:0] w);
        logic [NBITS-1:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < int'(DW); i++) f[1+i] = w[i];
        if (P_ON) f[DW+1] = (PAR == 1) ? ~(^w) : (^w);
        return f;
    endfunction

    // Called at a negedge; returns at the negedge where tx_ready is high.
    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        while (bus.tx_ready !== 1'b1 && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        ok = (bus.tx_ready === 1'b1);
    endtask

    task automatic sb_push(input logic [DW-1:0] d, input logic fe, input logic pe);
        exp_t e;
        e.data = d;
        e.ferr = fe;
        e.perr = pe;
        exp_q.push_back(e);
    endtask

    task automatic sb_drain();
        exp_t e;
        int   waited;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            waited = 0;
            while (rx_pulses <= rd_idx && waited < 4 * FRAME) begin
                @(negedge clk);
                waited++;
            end
            if (rx_pulses <= rd_idx) begin
                check("rx_valid timeout", rx_pulses, rd_idx + 1);
            end else begin
                check("rx_data", 32'(obs_data[rd_idx % 64]), 32'(e.data));
                check("frame_err", 32'(obs_ferr[rd_idx % 64]), 32'(e.ferr));
                check("parity_err", 32'(obs_perr[rd_idx % 64]), 32'(e.perr));
                rd_idx++;
            end
        end
        repeat (BIT) @(negedge clk);
        check("rx pulse count", rx_pulses, rd_idx);
    endtask

    // Accept one word and check every bit period of the serial output for its exact length.
    task automatic tx_frame_check(input logic [DW-1:0] w);
        bit               ok;
        int               good;
        logic [NBITS-1:0] fb;
        fb = frame_bits(w);
        wait_ready(ok);
        check("tx_ready before send", 32'(ok), 32'd1);
        if (ok) begin
            bus.tx_data  = w;
            bus.tx_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.tx_valid = 1'b0;
            bus.tx_data  = '0;
            for (int b = 0; b < int'(NBITS); b++) begin
                good = 0;
                for (int k = 0; k < int'(BIT); k++) begin
                    if (tx === fb[b]) good++;
                    if (b == int'(NBITS) - 1 && k == int'(BIT) - 1) begin
                        check("tx_ready last frame cycle", 32'(bus.tx_ready), 32'd0);
                        check("tx_busy last frame cycle", 32'(bus.tx_busy), 32'd1);
                    end
                    @(negedge clk);
                end
                check($sformatf("tx bit %0d cycles at level %0d", b, fb[b]), good, BIT);
            end
            check("tx_ready after frame", 32'(bus.tx_ready), 32'd1);
            check("tx_busy after frame", 32'(bus.tx_busy), 32'd0);
            check("tx idle after frame", 32'(tx), 32'd1);
        end
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        bit ok;
        wait_ready(ok);
        check("tx_ready for send", 32'(ok), 32'd1);
        bus.tx_data  = w;
        bus.tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic inject(input logic [DW-1:0] d, input logic stop, input logic pflip);
        rx_drv = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < int'(DW); i++) begin
            rx_drv = d[i];
            repeat (BIT) @(negedge clk);
        end
        if (P_ON) begin
            rx_drv = ((PAR == 1) ? ~(^d) : (^d)) ^ pflip;
            repeat (BIT) @(negedge clk);
        end
        rx_drv = stop;
        repeat (BIT) @(negedge clk);
        rx_drv = 1'b1;
        repeat (BIT) @(negedge clk);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] words [3];
        int            t_acc [3];
        int            base;
        bit            ok;

        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;

        vt[0] = '{9'h055, 1'b1, 1'b0, 9'h055, 1'b0, 1'b0};
        vt[1] = '{9'h055, 1'b0, 1'b0, 9'h055, 1'b1, 1'b0};
        vt[2] = '{9'h0A3, 1'b1, 1'b0, 9'h0A3, 1'b0, 1'b0};
        vt[3] = '{9'h1FF, 1'b1, 1'b1, 9'h1FF, 1'b0, P_ON};
        vt[4] = '{9'h001, 1'b1, 1'b0, 9'h001, 1'b0, 1'b0};

        // Reset values
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset tx", 32'(tx), 32'd1);
        check("reset tx_ready", 32'(bus.tx_ready), 32'd0);
        check("reset tx_busy", 32'(bus.tx_busy), 32'd0);
        check("reset rx_valid", 32'(bus.rx_valid), 32'd0);
        check("reset rx_data", 32'(bus.rx_data), 32'd0);
        check("reset frame_err", 32'(bus.frame_err), 32'd0);
        check("reset parity_err", 32'(bus.parity_err), 32'd0);
        rst = 1'b0;
        #1;
        check("tx_ready before first edge", 32'(bus.tx_ready), 32'd0);
        @(negedge clk);
        check("tx_ready after first edge", 32'(bus.tx_ready), 32'd1);
        check("tx idle after reset", 32'(tx), 32'd1);

        // Serial TX frames
        tx_frame_check(DW'(9'h0A5));
        tx_frame_check(DW'(9'h1FF));

        // Back-to-back loopback with tx_valid held high
        loop_en  = 1'b1;
        words[0] = DW'(9'h000);
        words[1] = DW'(9'h0FF);
        words[2] = DW'(9'h03C);
        for (int i = 0; i < 3; i++) begin
            bus.tx_data  = words[i];
            bus.tx_valid = 1'b1;
            wait_ready(ok);
            check("b2b tx_ready", 32'(ok), 32'd1);
            sb_push(words[i], 1'b0, 1'b0);
            @(posedge clk);
            t_acc[i] = cyc;
            @(negedge clk);
        end
        bus.tx_valid = 1'b0;
        check("b2b accept spacing 0-1", t_acc[1] - t_acc[0], FRAME + 1);
        check("b2b accept spacing 1-2", t_acc[2] - t_acc[1], FRAME + 1);
        sb_drain();

        // Glitch shorter than half a bit is a false start
        loop_en = 1'b0;
        repeat (BIT) @(negedge clk);
        base   = rx_pulses;
        rx_drv = 1'b0;
        repeat (40) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check("glitch gives no rx_valid", rx_pulses, base);

        // Injected receive vectors
        for (int i = 0; i < 5; i++) begin
            sb_push(vt[i].exp_data[DW-1:0], vt[i].exp_ferr, vt[i].exp_perr);
            inject(vt[i].data[DW-1:0], vt[i].stop, vt[i].pflip);
        end
        sb_drain();

        // Reset in the middle of DATA for both directions
        loop_en = 1'b1;
        send_word(DW'(9'h000));
        repeat (3 * BIT + BIT / 2) @(negedge clk);
        check("tx low mid data", 32'(tx), 32'd0);
        check("tx_busy mid data", 32'(bus.tx_busy), 32'd1);
        base = rx_pulses;
        rst  = 1'b1;
        @(posedge clk);
        #1;
        check("tx high on reset edge", 32'(tx), 32'd1);
        check("tx_busy cleared on reset", 32'(bus.tx_busy), 32'd0);
        check("tx_ready low in reset", 32'(bus.tx_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2 * FRAME) @(negedge clk);
        check("no rx_valid from aborted frame", rx_pulses, base);
        sb_push(DW'(9'h05A), 1'b0, 1'b0);
        send_word(DW'(9'h05A));
        sb_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_core.md
# uart_core

Parametrised full-duplex UART transceiver: one integrated baud generator, a 16x-oversampled receiver and a transmitter with a valid/ready input. It replaces the separate fixed 8N1 clock-divider/rx/tx trio under the board top level: it sits between the PLL clock domain and user logic. Data width, stop bits, parity and rate are all parameters.

## Interface
Parameters:
- CLK_FREQ, 27_000_000, input clock frequency in Hz
- BAUD_RATE, 115200, line rate in bit/s
- DATA_BITS, 8, payload bits per frame, legal 5..9
- STOP_BITS, 1, stop bits per frame, legal 1..2
- PARITY, 0, 0 = none, 1 = odd, 2 = even; effective only with UART_PARITY_EN

Ports:
- clk  in  1  the only clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- tx_data  in  DATA_BITS  word to send
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  transmitter accepts a word this cycle
- tx  out  1  serial line out, idles high
- rx  in  1  serial line in, asynchronous
- rx_data  out  DATA_BITS  last received word, held until next frame
- rx_valid  out  1  one-cycle pulse, a new word is on rx_data
- frame_err  out  1  qualifies rx_valid: stop bit sampled low
- parity_err  out  1  qualifies rx_valid: parity mismatch
- tx_busy  out  1  a frame is being shifted out

## Operation
- Baud tick: DIV = floor(CLK_FREQ / (BAUD_RATE*16)), minimum 1. A free-running counter raises a tick on 1 clk every DIV cycles. One bit time is 16 ticks. TX and RX share the counter.
- TX FSM IDLE -> START -> DATA -> PARITY (only if enabled and PARITY != 0) -> STOP -> IDLE.
  - Handshake: tx_ready = 1 only in IDLE. A word is accepted when tx_valid && tx_ready and is latched into the shift register.
  - Bit order: LSB first. Each state lasts exactly 16 ticks. STOP lasts 16*STOP_BITS ticks.
  - tx_busy = 1 in every state except IDLE. tx_data may change after acceptance.
- RX front end: 2-flop synchroniser on rx.
- RX FSM IDLE -> START -> DATA -> PARITY (optional) -> STOP -> IDLE.
  - A falling edge on the synchronised line in IDLE enters START.
  - At tick 8 of START the line must still be low. If it is high, this is a false start: return to IDLE with no rx_valid.
  - Data, parity and stop bits are sampled at tick 8 of each bit (mid-bit). Bits are assembled LSB first.
  - At the mid-point of the first stop bit: update rx_data, frame_err and parity_err, then pulse rx_valid for 1 cycle. The FSM returns to IDLE at that point, so a new start edge is accepted 8 ticks early.
  - A second stop bit is not checked on receive.
- No receive backpressure. An unread word is overwritten by the next frame.
- Parity: odd means that data bits plus the parity bit contain an odd number of ones. Even means an even number.

## Timing
- Reset values (rst high at a clk edge): tx = 1, tx_ready = 0, tx_busy = 0, rx_valid = 0, rx_data = 0, frame_err = 0, parity_err = 0. Both FSMs go to IDLE and the tick counter goes to 0.
- tx_ready rises on the first clk edge after rst is released.
- Reset mid-frame aborts the frame immediately. tx returns high on the same edge and no rx_valid is produced.
- TX latency: tx falls on the clk edge after acceptance. The frame then lasts (1 + DATA_BITS + P + STOP_BITS) * 16 * DIV cycles, where P is 1 when parity is active and 0 otherwise.
- RX latency: rx_valid occurs about (0.5 + 1 + DATA_BITS + P) bit times plus 2 sync cycles after the start edge.
- Simultaneous TX and RX are independent. A tx_valid held high across IDLE entry is accepted in the first IDLE cycle, which gives back-to-back frames with no idle gap.

## Configuration
- UART_PARITY_EN defined: the PARITY parameter is honoured. The parity bit is generated on TX, and checked on RX via parity_err.
- Undefined: parity logic is absent, PARITY is ignored (treated as 0), and parity_err is tied to 0.

## Test plan
Bench: CLK_FREQ = 1_600_000, BAUD_RATE = 10_000, which gives DIV = 10 and 160 cycles per bit.
- Reset check: hold rst for 5 cycles, then release -> all outputs at their reset values, tx_ready = 1 one cycle later, tx stays 1.
- 8N1 TX: send 0xA5 -> tx low for 160 cycles, then bits 1,0,1,0,0,1,0,1, then high. tx_ready returns after 1600 cycles.
- Loop tx to rx and send 0x00, 0xFF, 0x3C back-to-back -> three rx_valid pulses with matching data and frame_err = parity_err = 0.
- Glitch: rx low for 40 cycles -> no rx_valid, RX back in IDLE. Framing: frame 0x55 with stop bit low -> rx_valid with frame_err = 1.
- With UART_PARITY_EN, PARITY = 2, DATA_BITS = 9: 0x1FF is sent with parity bit 1. The same frame injected with parity bit 0 -> parity_err = 1.
- Assert rst in the middle of the DATA state of both FSMs -> tx = 1 on that edge, no rx_valid, and the next frame is received correctly.
